// File: rtl/restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock behind a start/done handshake.
// Define RDIV_SIGNED_EN for two's-complement operands (adds the FIX sign-correction state).
//
// state | meaning
// IDLE  | waiting for start; captures operands, short-circuits divide-by-zero
// CALC  | one trial subtraction per cycle, WIDTH cycles
// FIX   | sign correction of quotient/remainder (signed build only)
// DONE  | results valid, done pulses for this one cycle
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
`ifdef RDIV_SIGNED_EN
    S_FIX  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

`ifdef RDIV_SIGNED_EN
  logic neg_q_q;
  logic neg_r_q;

  always_comb begin
    dvd_mag = dividend_i[WIDTH-1] ? (~dividend_i + 1'b1) : dividend_i;
    dvs_mag = divisor_i[WIDTH-1]  ? (~divisor_i + 1'b1)  : divisor_i;
  end
`else
  always_comb begin
    dvd_mag = dividend_i;
    dvs_mag = divisor_i;
  end
`endif

  // The running remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted trial value needs the extra borrow bit.
  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    trial   = r_shift - {1'b0, dvs_q};
    if (trial[WIDTH]) begin
      r_d = r_shift[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      r_d = trial[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef RDIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend_i;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              r_q     <= '0;
              q_q     <= dvd_mag;
              dvs_q   <= dvs_mag;
              cnt_q   <= '0;
`ifdef RDIV_SIGNED_EN
              neg_q_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
              neg_r_q <= dividend_i[WIDTH-1];
`endif
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
`ifdef RDIV_SIGNED_EN
            state_q <= S_FIX;
`else
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
            state_q <= S_DONE;
`endif
          end
        end
`ifdef RDIV_SIGNED_EN
        S_FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          quot_q  <= neg_q_q ? (~q_q + 1'b1) : q_q;
          rem_q   <= neg_r_q ? (~r_q + 1'b1) : r_q;
          dbz_q   <= 1'b0;
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed-vector bench for restoring_divider (WIDTH=8); follows RDIV_SIGNED_EN if defined.
module tb_restoring_divider;
  localparam int W = 8;
`ifdef RDIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_by_zero_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;
  vec_t vecs[$];

  restoring_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Issue one start and wait (bounded) for done; lat counts edges from accept to done.
  task automatic do_op(input logic [7:0] dd, input logic [7:0] dv, output int lat, output bit bseen);
    @(negedge clk);
    dividend_i = dd;
    divisor_i  = dv;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    lat   = 1;
    bseen = busy_o;
    while (!done_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy_o) bseen = 1'b1;
    end
  endtask

  task automatic run_vec(input string nm, input logic [7:0] dd, input logic [7:0] dv,
                         input logic [7:0] q, input logic [7:0] r, input logic z);
    int lat;
    bit bseen;
    do_op(dd, dv, lat, bseen);
    check({nm, " latency"}, lat, z ? 1 : LAT);
    check({nm, " quotient"}, int'(quotient_o), int'(q));
    check({nm, " remainder"}, int'(remainder_o), int'(r));
    check({nm, " div_by_zero"}, int'(div_by_zero_o), int'(z));
    check({nm, " busy at done"}, int'(busy_o), 0);
    check({nm, " busy seen"}, int'(bseen), z ? 0 : 1);
    @(posedge clk);
    #1;
    check({nm, " done one cycle"}, int'(done_o), 0);
    check({nm, " quotient held"}, int'(quotient_o), int'(q));
  endtask

  initial begin
    int  lat;
    bit  saw_done;
`ifdef RDIV_SIGNED_EN
    vecs.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0});  // -7/2
    vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});  // -128/-1 wraps
    vecs.push_back('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0});
    vecs.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0});  // 7/-2
    vecs.push_back('{8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0});  // -7/-2
    vecs.push_back('{8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0});
    vecs.push_back('{8'h80, 8'h02, 8'hC0, 8'h00, 1'b0});  // -128/2
    vecs.push_back('{8'h05, 8'h0A, 8'h00, 8'h05, 1'b0});
    vecs.push_back('{8'hFB, 8'h0A, 8'h00, 8'hFB, 1'b0});  // -5/10
`else
    vecs.push_back('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0});
    vecs.push_back('{8'd200, 8'd0, 8'hFF, 8'd200, 1'b1});
    vecs.push_back('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0});
    vecs.push_back('{8'd3, 8'd250, 8'd0, 8'd3, 1'b0});
    vecs.push_back('{8'd50, 8'd5, 8'd10, 8'd0, 1'b0});
    vecs.push_back('{8'd0, 8'd1, 8'd0, 8'd0, 1'b0});
    vecs.push_back('{8'd255, 8'd255, 8'd1, 8'd0, 1'b0});
    vecs.push_back('{8'd254, 8'd255, 8'd0, 8'd254, 1'b0});
    vecs.push_back('{8'd128, 8'd2, 8'd64, 8'd0, 1'b0});
    vecs.push_back('{8'd17, 8'd16, 8'd1, 8'd1, 1'b0});
    vecs.push_back('{8'd0, 8'd0, 8'hFF, 8'd0, 1'b1});
`endif

    #1;
    check("reset busy", int'(busy_o), 0);
    check("reset done", int'(done_o), 0);
    check("reset quotient", int'(quotient_o), 0);
    check("reset remainder", int'(remainder_o), 0);
    check("reset div_by_zero", int'(div_by_zero_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: each run_vec issues start in the cycle after the previous done.
    foreach (vecs[i]) begin
      run_vec($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // Start while busy is ignored and operands are not resampled.
    @(negedge clk);
    dividend_i = 8'd100;
    divisor_i  = 8'd7;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    lat = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    dividend_i = 8'd50;
    divisor_i  = 8'd5;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    lat++;
    while (!done_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignore latency", lat, LAT);
    check("ignore quotient", int'(quotient_o), 14);
    check("ignore remainder", int'(remainder_o), 2);
    @(posedge clk);
    #1;
    check("ignore done one cycle", int'(done_o), 0);
    saw_done = 1'b0;
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      if (done_o) saw_done = 1'b1;
    end
    check("ignore no queued op", int'(saw_done), 0);

    // Reset mid-CALC abandons the operation.
    @(negedge clk);
    dividend_i = 8'd100;
    divisor_i  = 8'd7;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend_i = 8'd50;
    divisor_i  = 8'd5;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("midcalc busy", int'(busy_o), 1);
    check("midcalc quotient held", int'(quotient_o), 14);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset busy", int'(busy_o), 0);
    check("midreset done", int'(done_o), 0);
    check("midreset quotient", int'(quotient_o), 0);
    check("midreset remainder", int'(remainder_o), 0);
    check("midreset div_by_zero", int'(div_by_zero_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) saw_done = 1'b1;
    end
    check("after reset idle", int'(saw_done), 0);
    run_vec("post reset 50/5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0);

    // Sweep every dividend against divisor 13.
    for (int d = 0; d < 256; d++) begin
      logic [7:0] dd;
      int         qi;
      int         ri;
      logic [7:0] qe;
      logic [7:0] re;
      dd = d[7:0];
`ifdef RDIV_SIGNED_EN
      qi = int'($signed(dd)) / 13;
      ri = int'($signed(dd)) % 13;
`else
      qi = d / 13;
      ri = d % 13;
`endif
      qe = qi[7:0];
      re = ri[7:0];
      run_vec($sformatf("sweep %0d/13", d), dd, 8'd13, qe, re, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
